// File: rtl/front_hazard_unit_pkg.sv
// Shared Y86-64 encodings (icodes, register IDs, status codes) and widths for the
// fetch/decode front end and its hazard controller.
package front_hazard_unit_pkg;

    localparam int DATA_W   = 64;
    localparam int REG_W    = 4;
    localparam int ICODE_W  = 4;
    localparam int STAT_W   = 3;
    localparam int NUM_REGS = 15;

    typedef enum logic [ICODE_W-1:0] {
        I_HALT   = 4'h0,
        I_NOP    = 4'h1,
        I_RRMOVQ = 4'h2,
        I_IRMOVQ = 4'h3,
        I_RMMOVQ = 4'h4,
        I_MRMOVQ = 4'h5,
        I_OPQ    = 4'h6,
        I_JXX    = 4'h7,
        I_CALL   = 4'h8,
        I_RET    = 4'h9,
        I_PUSHQ  = 4'hA,
        I_POPQ   = 4'hB
    } icode_e;

    localparam logic [REG_W-1:0] R_RSP  = 4'h4;
    localparam logic [REG_W-1:0] R_NONE = 4'hF;

    typedef enum logic [STAT_W-1:0] {
        S_AOK = 3'd1,
        S_ADR = 3'd2,
        S_INS = 3'd3,
        S_HLT = 3'd4
    } stat_e;

    // Any status other than AOK means the instruction must not commit further.
    function automatic logic stat_exception(input logic [STAT_W-1:0] s);
        return (s == S_ADR) || (s == S_INS) || (s == S_HLT);
    endfunction

endpackage

// File: rtl/front_hazard_unit_if.sv
// Bundle of all front-end datapath and control signals; master drives the pipeline
// inputs, slave is the hazard unit itself.
interface front_hazard_unit_if;
    import front_hazard_unit_pkg::*;

    logic [DATA_W-1:0]  f_predPC_i;
    logic [DATA_W-1:0]  F_predPC_o;
    logic [ICODE_W-1:0] D_icode_i;
    logic [REG_W-1:0]   D_rA_i;
    logic [REG_W-1:0]   D_rB_i;
    logic [DATA_W-1:0]  D_valP_i;
    logic [STAT_W-1:0]  D_stat_i;
    logic [REG_W-1:0]   e_dstE_i;
    logic [REG_W-1:0]   M_dstM_i;
    logic [REG_W-1:0]   M_dstE_i;
    logic [REG_W-1:0]   W_dstM_i;
    logic [REG_W-1:0]   W_dstE_i;
    logic [DATA_W-1:0]  e_valE_i;
    logic [DATA_W-1:0]  m_valM_i;
    logic [DATA_W-1:0]  M_valE_i;
    logic [DATA_W-1:0]  W_valM_i;
    logic [DATA_W-1:0]  W_valE_i;
    logic [ICODE_W-1:0] E_icode_i;
    logic [ICODE_W-1:0] M_icode_i;
    logic [REG_W-1:0]   E_dstM_i;
    logic               e_cnd_i;
    logic [STAT_W-1:0]  m_stat_i;
    logic [STAT_W-1:0]  W_stat_i;
    logic [DATA_W-1:0]  d_valA_o;
    logic [DATA_W-1:0]  d_valB_o;
    logic [REG_W-1:0]   d_srcA_o;
    logic [REG_W-1:0]   d_srcB_o;
    logic [REG_W-1:0]   d_dstE_o;
    logic [REG_W-1:0]   d_dstM_o;
    logic [STAT_W-1:0]  d_stat_o;
    logic               F_stall_o;
    logic               D_stall_o;
    logic               D_bubble_o;
    logic               E_bubble_o;
    logic               M_bubble_o;
    logic               W_stall_o;

    modport master (
        output f_predPC_i, D_icode_i, D_rA_i, D_rB_i, D_valP_i, D_stat_i,
               e_dstE_i, M_dstM_i, M_dstE_i, W_dstM_i, W_dstE_i,
               e_valE_i, m_valM_i, M_valE_i, W_valM_i, W_valE_i,
               E_icode_i, M_icode_i, E_dstM_i, e_cnd_i, m_stat_i, W_stat_i,
        input  F_predPC_o, d_valA_o, d_valB_o, d_srcA_o, d_srcB_o, d_dstE_o,
               d_dstM_o, d_stat_o, F_stall_o, D_stall_o, D_bubble_o, E_bubble_o,
               M_bubble_o, W_stall_o
    );

    modport slave (
        input  f_predPC_i, D_icode_i, D_rA_i, D_rB_i, D_valP_i, D_stat_i,
               e_dstE_i, M_dstM_i, M_dstE_i, W_dstM_i, W_dstE_i,
               e_valE_i, m_valM_i, M_valE_i, W_valM_i, W_valE_i,
               E_icode_i, M_icode_i, E_dstM_i, e_cnd_i, m_stat_i, W_stat_i,
        output F_predPC_o, d_valA_o, d_valB_o, d_srcA_o, d_srcB_o, d_dstE_o,
               d_dstM_o, d_stat_o, F_stall_o, D_stall_o, D_bubble_o, E_bubble_o,
               M_bubble_o, W_stall_o
    );

endinterface

// File: rtl/front_hazard_unit_controller.sv
// Pipeline hazard controller: load/use stalls, return stalls, branch mispredict
// bubbles and exception-driven memory/writeback control.
module controller
    import front_hazard_unit_pkg::*;
(
    input  logic [ICODE_W-1:0] D_icode_i,
    input  logic [ICODE_W-1:0] E_icode_i,
    input  logic [ICODE_W-1:0] M_icode_i,
    input  logic [REG_W-1:0]   E_dstM_i,
    input  logic [REG_W-1:0]   d_srcA_i,
    input  logic [REG_W-1:0]   d_srcB_i,
    input  logic               e_cnd_i,
    input  logic [STAT_W-1:0]  m_stat_i,
    input  logic [STAT_W-1:0]  W_stat_i,
    output logic               F_stall_o,
    output logic               D_stall_o,
    output logic               D_bubble_o,
    output logic               E_bubble_o,
    output logic               M_bubble_o,
    output logic               W_stall_o
);

    logic load_use;
    logic ret_pend;
    logic mispred;

    // E_dstM of RNONE must not alias an unused RNONE source.
    assign load_use = (E_icode_i == I_MRMOVQ || E_icode_i == I_POPQ) &&
                      (E_dstM_i != R_NONE) &&
                      (E_dstM_i == d_srcA_i || E_dstM_i == d_srcB_i);
    assign ret_pend = (D_icode_i == I_RET) || (E_icode_i == I_RET) || (M_icode_i == I_RET);
    assign mispred  = (E_icode_i == I_JXX) && !e_cnd_i;

    assign F_stall_o  = load_use || ret_pend;
    assign D_stall_o  = load_use;
    assign D_bubble_o = mispred || (ret_pend && !load_use);
    assign E_bubble_o = mispred || load_use;
    assign M_bubble_o = stat_exception(m_stat_i) || stat_exception(W_stat_i);
    assign W_stall_o  = stat_exception(W_stat_i);

endmodule

// File: rtl/front_hazard_unit_decode.sv
// Decode stage: source/destination selection, 15-entry register file and
// operand forwarding from the later pipeline stages.
module decode
    import front_hazard_unit_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic [ICODE_W-1:0] D_icode_i,
    input  logic [REG_W-1:0]   D_rA_i,
    input  logic [REG_W-1:0]   D_rB_i,
    input  logic [DATA_W-1:0]  D_valP_i,
    input  logic [STAT_W-1:0]  D_stat_i,
    input  logic [REG_W-1:0]   e_dstE_i,
    input  logic [REG_W-1:0]   M_dstM_i,
    input  logic [REG_W-1:0]   M_dstE_i,
    input  logic [REG_W-1:0]   W_dstM_i,
    input  logic [REG_W-1:0]   W_dstE_i,
    input  logic [DATA_W-1:0]  e_valE_i,
    input  logic [DATA_W-1:0]  m_valM_i,
    input  logic [DATA_W-1:0]  M_valE_i,
    input  logic [DATA_W-1:0]  W_valM_i,
    input  logic [DATA_W-1:0]  W_valE_i,
    output logic [DATA_W-1:0]  d_valA_o,
    output logic [DATA_W-1:0]  d_valB_o,
    output logic [REG_W-1:0]   d_srcA_o,
    output logic [REG_W-1:0]   d_srcB_o,
    output logic [REG_W-1:0]   d_dstE_o,
    output logic [REG_W-1:0]   d_dstM_o,
    output logic [STAT_W-1:0]  d_stat_o
);

    logic [NUM_REGS-1:0][DATA_W-1:0] rf_q;

    // Flop-based register file: reads must be combinational and reset clears every entry.
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
        localparam logic [REG_W-1:0] REG_ID = REG_W'(gi);
        logic [DATA_W-1:0] reg_q;

        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                reg_q <= '0;
            end else if (W_dstM_i == REG_ID) begin
                reg_q <= W_valM_i;
            end else if (W_dstE_i == REG_ID) begin
                reg_q <= W_valE_i;
            end
        end

        assign rf_q[gi] = reg_q;
    end

    always_comb begin
        d_srcA_o = R_NONE;
        d_srcB_o = R_NONE;
        d_dstE_o = R_NONE;
        d_dstM_o = R_NONE;
        case (D_icode_i)
            I_RRMOVQ: begin d_srcA_o = D_rA_i; d_dstE_o = D_rB_i; end
            I_IRMOVQ: d_dstE_o = D_rB_i;
            I_RMMOVQ: begin d_srcA_o = D_rA_i; d_srcB_o = D_rB_i; end
            I_MRMOVQ: begin d_srcB_o = D_rB_i; d_dstM_o = D_rA_i; end
            I_OPQ:    begin d_srcA_o = D_rA_i; d_srcB_o = D_rB_i; d_dstE_o = D_rB_i; end
            I_CALL:   begin d_srcB_o = R_RSP; d_dstE_o = R_RSP; end
            I_RET:    begin d_srcA_o = R_RSP; d_srcB_o = R_RSP; d_dstE_o = R_RSP; end
            I_PUSHQ:  begin d_srcA_o = D_rA_i; d_srcB_o = R_RSP; d_dstE_o = R_RSP; end
            I_POPQ:   begin d_srcA_o = R_RSP; d_srcB_o = R_RSP; d_dstE_o = R_RSP; d_dstM_o = D_rA_i; end
            default:  ;
        endcase
    end

    // Youngest producer wins; fall back to the architectural value.
    function automatic logic [DATA_W-1:0] fwd_val(input logic [REG_W-1:0] src);
        if (src == R_NONE)   return '0;
        if (src == e_dstE_i) return e_valE_i;
        if (src == M_dstM_i) return m_valM_i;
        if (src == M_dstE_i) return M_valE_i;
        if (src == W_dstM_i) return W_valM_i;
        if (src == W_dstE_i) return W_valE_i;
        return rf_q[src];
    endfunction

    always_comb begin
        d_valA_o = fwd_val(d_srcA_o);
        if (D_icode_i == I_CALL || D_icode_i == I_JXX) begin
            d_valA_o = D_valP_i;
        end
        d_valB_o = fwd_val(d_srcB_o);
    end

    assign d_stat_o = D_stat_i;

endmodule

// File: rtl/front_hazard_unit_f_pipe_reg.sv
// Fetch pipeline register holding the predicted PC; hold on stall, clear on bubble.
module F_pipe_reg
    import front_hazard_unit_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              stall_i,
    input  logic              bubble_i,
    input  logic [DATA_W-1:0] pred_pc_i,
    output logic [DATA_W-1:0] pred_pc_o
);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pred_pc_o <= '0;
        end else if (bubble_i) begin
            pred_pc_o <= '0;
        end else if (!stall_i) begin
            pred_pc_o <= pred_pc_i;
        end
    end

endmodule

// File: rtl/front_hazard_unit.sv
// Front-end hazard unit top: fetch PC register, decode/forwarding and hazard control.
module front_hazard_unit
    import front_hazard_unit_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_n_i,
    front_hazard_unit_if.slave bus
);

    logic [REG_W-1:0] d_srcA;
    logic [REG_W-1:0] d_srcB;
    logic             f_stall;

    F_pipe_reg u_f_pipe_reg (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .stall_i   (f_stall),
        .bubble_i  (1'b0),
        .pred_pc_i (bus.f_predPC_i),
        .pred_pc_o (bus.F_predPC_o)
    );

    decode u_decode (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .D_icode_i (bus.D_icode_i),
        .D_rA_i    (bus.D_rA_i),
        .D_rB_i    (bus.D_rB_i),
        .D_valP_i  (bus.D_valP_i),
        .D_stat_i  (bus.D_stat_i),
        .e_dstE_i  (bus.e_dstE_i),
        .M_dstM_i  (bus.M_dstM_i),
        .M_dstE_i  (bus.M_dstE_i),
        .W_dstM_i  (bus.W_dstM_i),
        .W_dstE_i  (bus.W_dstE_i),
        .e_valE_i  (bus.e_valE_i),
        .m_valM_i  (bus.m_valM_i),
        .M_valE_i  (bus.M_valE_i),
        .W_valM_i  (bus.W_valM_i),
        .W_valE_i  (bus.W_valE_i),
        .d_valA_o  (bus.d_valA_o),
        .d_valB_o  (bus.d_valB_o),
        .d_srcA_o  (d_srcA),
        .d_srcB_o  (d_srcB),
        .d_dstE_o  (bus.d_dstE_o),
        .d_dstM_o  (bus.d_dstM_o),
        .d_stat_o  (bus.d_stat_o)
    );

    controller u_controller (
        .D_icode_i  (bus.D_icode_i),
        .E_icode_i  (bus.E_icode_i),
        .M_icode_i  (bus.M_icode_i),
        .E_dstM_i   (bus.E_dstM_i),
        .d_srcA_i   (d_srcA),
        .d_srcB_i   (d_srcB),
        .e_cnd_i    (bus.e_cnd_i),
        .m_stat_i   (bus.m_stat_i),
        .W_stat_i   (bus.W_stat_i),
        .F_stall_o  (f_stall),
        .D_stall_o  (bus.D_stall_o),
        .D_bubble_o (bus.D_bubble_o),
        .E_bubble_o (bus.E_bubble_o),
        .M_bubble_o (bus.M_bubble_o),
        .W_stall_o  (bus.W_stall_o)
    );

    assign bus.d_srcA_o  = d_srcA;
    assign bus.d_srcB_o  = d_srcB;
    assign bus.F_stall_o = f_stall;

endmodule

// File: tb/tb_front_hazard_unit.sv
// Scoreboard bench: directed vectors push hand-computed expectations; a monitor
// pops and compares at the falling edge whenever a vector is presented.
module tb_front_hazard_unit;
    import front_hazard_unit_pkg::*;

    typedef struct {
        int          id;
        logic [63:0] pc;
        logic [63:0] va;
        logic [63:0] vb;
        logic [3:0]  sa;
        logic [3:0]  sb;
        logic [3:0]  de;
        logic [3:0]  dm;
        logic [2:0]  st;
        logic [5:0]  ctl;   // {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall}
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic chk_valid = 1'b0;
    exp_t sb_q[$];
    int   checks = 0;
    int   failures = 0;
    int   vec_id = 0;

    front_hazard_unit_if bus();

    front_hazard_unit dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string name, input int id, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL vec%0d %s actual=%h required=%h", id, name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (chk_valid) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL scoreboard_empty actual=0 required=1");
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                cmp("F_predPC", e.id, bus.F_predPC_o, e.pc);
                cmp("d_valA",   e.id, bus.d_valA_o, e.va);
                cmp("d_valB",   e.id, bus.d_valB_o, e.vb);
                cmp("d_srcA",   e.id, 64'(bus.d_srcA_o), 64'(e.sa));
                cmp("d_srcB",   e.id, 64'(bus.d_srcB_o), 64'(e.sb));
                cmp("d_dstE",   e.id, 64'(bus.d_dstE_o), 64'(e.de));
                cmp("d_dstM",   e.id, 64'(bus.d_dstM_o), 64'(e.dm));
                cmp("d_stat",   e.id, 64'(bus.d_stat_o), 64'(e.st));
                cmp("controls", e.id,
                    64'({bus.F_stall_o, bus.D_stall_o, bus.D_bubble_o,
                         bus.E_bubble_o, bus.M_bubble_o, bus.W_stall_o}), 64'(e.ctl));
                $display("vec%0d pc=%0h valA=%0h valB=%0h ctl=%b", e.id, bus.F_predPC_o,
                         bus.d_valA_o, bus.d_valB_o,
                         {bus.F_stall_o, bus.D_stall_o, bus.D_bubble_o,
                          bus.E_bubble_o, bus.M_bubble_o, bus.W_stall_o});
            end
        end
    end

    task automatic defaults();
        bus.D_icode_i = I_NOP;  bus.D_rA_i = R_NONE; bus.D_rB_i = R_NONE;
        bus.D_valP_i  = '0;     bus.D_stat_i = S_AOK;
        bus.e_dstE_i  = R_NONE; bus.M_dstM_i = R_NONE; bus.M_dstE_i = R_NONE;
        bus.W_dstM_i  = R_NONE; bus.W_dstE_i = R_NONE;
        bus.e_valE_i  = '0; bus.m_valM_i = '0; bus.M_valE_i = '0;
        bus.W_valM_i  = '0; bus.W_valE_i = '0;
        bus.E_icode_i = I_NOP; bus.M_icode_i = I_NOP; bus.E_dstM_i = R_NONE;
        bus.e_cnd_i   = 1'b1;  bus.m_stat_i = S_AOK;  bus.W_stat_i = S_AOK;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        defaults();
    endtask

    task automatic expect_vec(input logic [63:0] pc, input logic [63:0] va, input logic [63:0] vb,
                              input logic [3:0] sa, input logic [3:0] sb, input logic [3:0] de,
                              input logic [3:0] dm, input logic [2:0] st, input logic [5:0] ctl);
        exp_t e;
        e.id = vec_id; e.pc = pc; e.va = va; e.vb = vb; e.sa = sa; e.sb = sb;
        e.de = de; e.dm = dm; e.st = st; e.ctl = ctl;
        sb_q.push_back(e);
        vec_id++;
        chk_valid = 1'b1;
        @(negedge clk);
        #1;
        chk_valid = 1'b0;
    endtask

    initial begin
        #100000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        rst_n = 1'b0;
        defaults();
        bus.f_predPC_i = 64'd10;
        // v0: held in reset across edges
        cyc(); cyc();
        expect_vec(0, 0, 0, 4'hF, 4'hF, 4'hF, 4'hF, 3'd1, 6'b000000);
        // v1: reset released, no edge yet
        cyc(); rst_n = 1'b1;
        expect_vec(0, 0, 0, 4'hF, 4'hF, 4'hF, 4'hF, 3'd1, 6'b000000);
        // v2: first edge loads 10
        cyc();
        expect_vec(64'd10, 0, 0, 4'hF, 4'hF, 4'hF, 4'hF, 3'd1, 6'b000000);
        // v3: RET in decode stalls fetch
        cyc(); bus.f_predPC_i = 64'd20; bus.D_icode_i = I_RET;
        expect_vec(64'd10, 0, 0, 4'h4, 4'h4, 4'h4, 4'hF, 3'd1, 6'b101000);
        // v4: stalled edge held 10
        cyc();
        expect_vec(64'd10, 0, 0, 4'hF, 4'hF, 4'hF, 4'hF, 3'd1, 6'b000000);
        // v5: now 20; schedule write r3=55
        cyc(); bus.W_dstE_i = 4'd3; bus.W_valE_i = 64'd55;
        expect_vec(64'd20, 0, 0, 4'hF, 4'hF, 4'hF, 4'hF, 3'd1, 6'b000000);
        // v6: OPQ r3,r3 reads 55 from register file
        cyc(); bus.D_icode_i = I_OPQ; bus.D_rA_i = 4'd3; bus.D_rB_i = 4'd3;
        expect_vec(64'd20, 64'd55, 64'd55, 4'd3, 4'd3, 4'd3, 4'hF, 3'd1, 6'b000000);
        // v7: execute beats memory; M_dstM feeds valB
        cyc(); bus.D_icode_i = I_OPQ; bus.D_rA_i = 4'd2; bus.D_rB_i = 4'd5;
        bus.e_dstE_i = 4'd2; bus.e_valE_i = 64'd7; bus.M_dstE_i = 4'd2; bus.M_valE_i = 64'd9;
        bus.M_dstM_i = 4'd5; bus.m_valM_i = 64'd11;
        expect_vec(64'd20, 64'd7, 64'd11, 4'd2, 4'd5, 4'd5, 4'hF, 3'd1, 6'b000000);
        // v8: memory beats writeback; W_dstM feeds valB; writes r2=13, r3=21
        cyc(); bus.D_icode_i = I_OPQ; bus.D_rA_i = 4'd2; bus.D_rB_i = 4'd3;
        bus.M_dstE_i = 4'd2; bus.M_valE_i = 64'd9; bus.W_dstE_i = 4'd2; bus.W_valE_i = 64'd13;
        bus.W_dstM_i = 4'd3; bus.W_valM_i = 64'd21;
        expect_vec(64'd20, 64'd9, 64'd21, 4'd2, 4'd3, 4'd3, 4'hF, 3'd1, 6'b000000);
        // v9: both write ports target r6; valM must win
        cyc(); bus.W_dstE_i = 4'd6; bus.W_valE_i = 64'd100; bus.W_dstM_i = 4'd6; bus.W_valM_i = 64'd200;
        expect_vec(64'd20, 0, 0, 4'hF, 4'hF, 4'hF, 4'hF, 3'd1, 6'b000000);
        // v10: read back r2 and r6
        cyc(); bus.D_icode_i = I_OPQ; bus.D_rA_i = 4'd2; bus.D_rB_i = 4'd6;
        expect_vec(64'd20, 64'd13, 64'd200, 4'd2, 4'd6, 4'd6, 4'hF, 3'd1, 6'b000000);
        // v11: load/use on srcA, status passthrough
        cyc(); bus.D_icode_i = I_OPQ; bus.D_rA_i = 4'd2; bus.D_rB_i = 4'd6; bus.D_stat_i = S_ADR;
        bus.E_icode_i = I_MRMOVQ; bus.E_dstM_i = 4'd2;
        expect_vec(64'd20, 64'd13, 64'd200, 4'd2, 4'd6, 4'd6, 4'hF, 3'd2, 6'b110100);
        // v12: load/use combined with RET suppresses D bubble
        cyc(); bus.D_icode_i = I_RET; bus.E_icode_i = I_POPQ; bus.E_dstM_i = 4'd4;
        expect_vec(64'd20, 0, 0, 4'h4, 4'h4, 4'h4, 4'hF, 3'd1, 6'b110100);
        // v13: mispredicted branch
        cyc(); bus.E_icode_i = I_JXX; bus.e_cnd_i = 1'b0;
        expect_vec(64'd20, 0, 0, 4'hF, 4'hF, 4'hF, 4'hF, 3'd1, 6'b001100);
        // v14: taken branch is fine; CALL passes valP as valA
        cyc(); bus.E_icode_i = I_JXX; bus.D_icode_i = I_CALL; bus.D_valP_i = 64'h1234;
        expect_vec(64'd20, 64'h1234, 0, 4'hF, 4'h4, 4'h4, 4'hF, 3'd1, 6'b000000);
        // v15: RET in memory stage
        cyc(); bus.M_icode_i = I_RET;
        expect_vec(64'd20, 0, 0, 4'hF, 4'hF, 4'hF, 4'hF, 3'd1, 6'b101000);
        // v16..v18: exception status
        cyc(); bus.m_stat_i = S_ADR;
        expect_vec(64'd20, 0, 0, 4'hF, 4'hF, 4'hF, 4'hF, 3'd1, 6'b000010);
        cyc(); bus.W_stat_i = S_HLT;
        expect_vec(64'd20, 0, 0, 4'hF, 4'hF, 4'hF, 4'hF, 3'd1, 6'b000011);
        cyc(); bus.m_stat_i = S_INS;
        expect_vec(64'd20, 0, 0, 4'hF, 4'hF, 4'hF, 4'hF, 3'd1, 6'b000010);
        // v19: E_dstM=RNONE never matches an RNONE source
        cyc(); bus.E_icode_i = I_MRMOVQ; bus.D_icode_i = I_OPQ; bus.D_rA_i = 4'hF; bus.D_rB_i = 4'd6;
        expect_vec(64'd20, 0, 64'd200, 4'hF, 4'd6, 4'd6, 4'hF, 3'd1, 6'b000000);
        // v20..v22: remaining decode patterns
        cyc(); bus.D_icode_i = I_MRMOVQ; bus.D_rA_i = 4'd8; bus.D_rB_i = 4'd3;
        expect_vec(64'd20, 0, 64'd21, 4'hF, 4'd3, 4'hF, 4'd8, 3'd1, 6'b000000);
        cyc(); bus.D_icode_i = I_POPQ; bus.D_rA_i = 4'd9;
        expect_vec(64'd20, 0, 0, 4'h4, 4'h4, 4'h4, 4'd9, 3'd1, 6'b000000);
        cyc(); bus.D_icode_i = I_RRMOVQ; bus.D_rA_i = 4'd1; bus.D_rB_i = 4'd7;
        bus.W_dstE_i = 4'd1; bus.W_valE_i = 64'd77;
        expect_vec(64'd20, 64'd77, 0, 4'd1, 4'hF, 4'd7, 4'hF, 3'd1, 6'b000000);
        // v23: asynchronous reset mid-run clears PC and register file at once
        cyc(); rst_n = 1'b0; bus.D_icode_i = I_OPQ; bus.D_rA_i = 4'd3; bus.D_rB_i = 4'd2;
        expect_vec(0, 0, 0, 4'd3, 4'd2, 4'd2, 4'hF, 3'd1, 6'b000000);

        cyc();
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/front_hazard_unit.md
FRONT_HAZARD_UNIT -- requirements
Module: front_hazard_unit

Interface
REQ-001 SHALL have no parameters; widths fixed: data 64, register ID 4, icode 4, stat 3.
REQ-002 clk_i  in  1  single clock, rising edge.
REQ-003 rst_n_i  in  1  reset, asynchronous, active-low.
REQ-004 f_predPC_i  in  64  predicted next PC from fetch.
REQ-005 F_predPC_o  out  64  registered predicted PC.
REQ-006 D_icode_i, D_rA_i, D_rB_i  in  4 each  decode-stage instruction fields.
REQ-007 D_valP_i  in  64 / D_stat_i  in  3  decode-stage next-sequential PC and status.
REQ-008 e_dstE_i, M_dstM_i, M_dstE_i, W_dstM_i, W_dstE_i  in  4 each  forwarding destination IDs.
REQ-009 e_valE_i, m_valM_i, M_valE_i, W_valM_i, W_valE_i  in  64 each  forwarding values.
REQ-010 E_icode_i, M_icode_i  in  4 / E_dstM_i  in  4 / e_cnd_i  in  1 / m_stat_i, W_stat_i  in  3  hazard-control inputs.
REQ-011 d_valA_o, d_valB_o  out  64 / d_srcA_o, d_srcB_o, d_dstE_o, d_dstM_o  out  4 / d_stat_o  out  3  decode results.
REQ-012 F_stall_o, D_stall_o, D_bubble_o, E_bubble_o, M_bubble_o, W_stall_o  out  1 each  pipeline controls.

Function
REQ-013 Encodings: HALT 0, NOP 1, RRMOVQ 2, IRMOVQ 3, RMMOVQ 4, MRMOVQ 5, OPQ 6, JXX 7, CALL 8, RET 9, PUSHQ A, POPQ B; RSP 4, RNONE F; stat AOK 1, ADR 2, INS 3, HLT 4.
REQ-014 F register: on rising edge, F_predPC_o <= f_predPC_i unless F_stall_o=1 (hold); F bubble tied inactive.
REQ-015 srcA = rA for RRMOVQ/RMMOVQ/OPQ/PUSHQ; RSP for POPQ/RET; else RNONE.
REQ-016 srcB = rB for OPQ/RMMOVQ/MRMOVQ; RSP for PUSHQ/POPQ/CALL/RET; else RNONE.
REQ-017 dstE = rB for RRMOVQ/IRMOVQ/OPQ; RSP for PUSHQ/POPQ/CALL/RET; else RNONE.
REQ-018 dstM = rA for MRMOVQ/POPQ; else RNONE.
REQ-019 d_valA = D_valP_i for CALL/JXX; else forwarded srcA value.
REQ-020 Forwarding (valA and valB, srcX != RNONE), first match wins: e_dstE->e_valE, M_dstM->m_valM, M_dstE->M_valE, W_dstM->W_valM, W_dstE->W_valE, else register file; srcX = RNONE -> 0.
REQ-021 Register file: 15 x 64-bit (IDs 0..14); combinational read; rising-edge write of W_valE to W_dstE and W_valM to W_dstM when != RNONE; same ID both ports -> W_valM wins.
REQ-022 d_stat_o = D_stat_i; all decode outputs combinational (zero latency).
REQ-023 loaduse = E_icode in {MRMOVQ,POPQ} and E_dstM_i in {d_srcA,d_srcB} and E_dstM_i != RNONE.
REQ-024 ret_pend = RET in any of D_icode_i, E_icode_i, M_icode_i; mispred = E_icode_i=JXX and e_cnd_i=0.
REQ-025 F_stall = loaduse or ret_pend; D_stall = loaduse.
REQ-026 D_bubble = mispred or (ret_pend and not loaduse); E_bubble = mispred or loaduse.
REQ-027 M_bubble = m_stat in {ADR,INS,HLT} or W_stat in {ADR,INS,HLT}; W_stall = W_stat in {ADR,INS,HLT}.
REQ-028 Control outputs purely combinational; X-free when all inputs defined.

Reset
REQ-029 rst_n_i low asynchronously clears F_predPC_o to 0 and all 15 registers to 0; held until rst_n_i high and next edge.
REQ-030 Reset mid-operation discards pending writes; controls remain combinational functions of inputs.

Structure
REQ-031 Opcodes, register IDs and stat codes SHALL live in the shared defines package, not locally.
REQ-032 Sub-modules: F_pipe_reg (PC register), decode (src/dst, regfile, forwarding), controller (hazards); top wires controller F_stall to F_pipe_reg.

Verification
REQ-033 Reset then f_predPC_i=10, one edge -> F_predPC_o=10; F_stall_o=1 at next edge with f_predPC_i=20 -> stays 10.
REQ-034 W_dstE=3, W_valE=55, one edge; then D OPQ rA=3 rB=3 -> d_valA=d_valB=55, d_dstE=3.
REQ-035 D OPQ rA=2, e_dstE=2 e_valE=7 and M_dstE=2 M_valE=9 -> d_valA=7 (e wins).
REQ-036 E MRMOVQ E_dstM=2, D OPQ rA=2 -> F_stall=1, D_stall=1, E_bubble=1, D_bubble=0.
REQ-037 E JXX e_cnd=0 -> D_bubble=1, E_bubble=1; D RET alone -> F_stall=1, D_bubble=1.
REQ-038 m_stat=ADR -> M_bubble=1, W_stall=0; W_stat=HLT -> M_bubble=1, W_stall=1.
